// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Word width, FSM state encoding and the address legality rule.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Word-aligned, and no address bits set above the word-index field.
    function automatic logic addr_legal(input logic [WORD_W-1:0] addr, input int addr_w);
        return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: synchronous write port and asynchronous read port, no reset.
// Zero-cycle read; the write lands at the clock edge; there is no backpressure.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clears the array after reset, serves stores in one cycle, loads with READ_LAT wait states.
// Stall is held high during INIT and while a load is waiting; misaligned or out-of-range accesses are suppressed and logged.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] Addr,
    input  logic [WORD_W-1:0] Din,
    output logic [WORD_W-1:0] Dout,
    output logic              Stall,
    output logic              AddrErr,
    output logic [WORD_W-1:0] ErrAddr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [2:0]        cnt_q;
    logic [WORD_W-1:0] dout_q;
    logic [WORD_W-1:0] resp_q;
    logic              err_q;
    logic [WORD_W-1:0] err_addr_q;

    logic [ADDR_W-1:0] idx;
    logic              legal;
    logic              is_rd;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic              start_wait;
    logic              err_set;

    assign idx   = Addr[ADDR_W+1:2];
    assign legal = addr_legal(Addr, ADDR_W);
    // A simultaneous read and write is treated as a plain write.
    assign is_rd = MemRead & ~MemWrite;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (idx),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        Stall      = 1'b0;
        Dout       = dout_q;
        arr_we     = 1'b0;
        arr_waddr  = idx;
        arr_wdata  = Din;
        start_wait = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            S_INIT: begin
                Stall     = 1'b1;
                arr_we    = 1'b1;
                arr_waddr = ptr_q;
                arr_wdata = '0;
                if (ptr_q == PTR_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if ((MemRead || MemWrite) && !legal) begin
                    err_set = 1'b1;
                    if (is_rd) begin
                        Dout = '0;
                    end
                end else if (MemWrite) begin
                    arr_we = 1'b1;
                end else if (is_rd) begin
                    if (READ_LAT == 0) begin
                        Dout = arr_rdata;
                    end else begin
                        // The request cycle is the first of the READ_LAT stalled cycles.
                        Stall      = 1'b1;
                        start_wait = 1'b1;
                        state_d    = (READ_LAT == 1) ? S_RESP : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                Stall = 1'b1;
                if (int'(cnt_q) + 1 >= READ_LAT) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                Dout    = resp_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            ptr_q      <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= Dout;
            if (state_q == S_INIT) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if (start_wait) begin
                cnt_q  <= 3'd1;
                resp_q <= arr_rdata;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + 3'd1;
            end
            // Only the first fault is kept until the next reset.
            if (err_set && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= Addr;
            end
        end
    end

    assign AddrErr = err_q;
    assign ErrAddr = err_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench driving one stimulus stream into a READ_LAT=0 and a READ_LAT=3 responder.
// Expected values come from a word-array model of memory and the sticky error rule.
module tb_dmem_responder;

    localparam int LAT3 = 3;

    logic        clock;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] din;

    logic [31:0] dout0, dout3, erraddr0, erraddr3;
    logic        stall0, stall3, err0, err3;

    logic [31:0] model_mem [256];
    logic        exp_err;
    logic [31:0] exp_erraddr;
    logic [31:0] last0, last3;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .READ_LAT(0)) u_dut0 (
        .clock    (clock),
        .reset    (reset),
        .MemRead  (mem_read),
        .MemWrite (mem_write),
        .Addr     (addr),
        .Din      (din),
        .Dout     (dout0),
        .Stall    (stall0),
        .AddrErr  (err0),
        .ErrAddr  (erraddr0)
    );

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .READ_LAT(LAT3)) u_dut3 (
        .clock    (clock),
        .reset    (reset),
        .MemRead  (mem_read),
        .MemWrite (mem_write),
        .Addr     (addr),
        .Din      (din),
        .Dout     (dout3),
        .Stall    (stall3),
        .AddrErr  (err3),
        .ErrAddr  (erraddr3)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        exp_err     = 1'b0;
        exp_erraddr = 32'h0;
        last0       = 32'h0;
        last3       = 32'h0;
    endtask

    // Counts stalled cycles from the current sample point until both DUTs leave INIT.
    task automatic wait_init();
        int n0 = 0;
        int n3 = 0;
        for (int c = 0; c < 400; c++) begin
            n0 += int'(stall0);
            n3 += int'(stall3);
            if (!stall0 && !stall3) break;
            @(negedge clock);
            #1;
        end
        chk("init_stall_cycles0", 32'(n0), 32'd256);
        chk("init_stall_cycles3", 32'(n3), 32'd256);
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic        legal;
        logic        is_rd;
        logic [7:0]  idx;
        logic [31:0] expv;
        int          n;
        @(negedge clock);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        din       = d;
        #1;
        legal = (a % 4 == 0) && (a < 32'd1024);
        idx   = 8'(a / 4);
        is_rd = rd && !wr;
        expv  = (is_rd && legal) ? model_mem[idx] : 32'h0;

        chk("adderr0", 32'(err0), 32'(exp_err));
        chk("adderr3", 32'(err3), 32'(exp_err));
        chk("erraddr0", erraddr0, exp_erraddr);
        chk("erraddr3", erraddr3, exp_erraddr);
        chk("stall0", 32'(stall0), 32'd0);
        chk("dout0", dout0, is_rd ? expv : last0);

        if (is_rd && legal) begin
            chk("stall3_first", 32'(stall3), 32'd1);
            n = 1;
            while (n < 20) begin
                @(negedge clock);
                #1;
                if (!stall3) break;
                n++;
            end
            chk("stall3_cycles", 32'(n), 32'(LAT3));
            chk("dout3_resp", dout3, expv);
        end else begin
            chk("stall3", 32'(stall3), 32'd0);
            chk("dout3", dout3, is_rd ? expv : last3);
        end

        if ((rd || wr) && !legal) begin
            if (!exp_err) begin
                exp_err     = 1'b1;
                exp_erraddr = a;
            end
        end else if (wr) begin
            model_mem[idx] = d;
        end
        if (is_rd) begin
            last0 = expv;
            last3 = expv;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        din       = 32'h0;
        model_reset();

        #5;
        chk("rst_stall0", 32'(stall0), 32'd1);
        chk("rst_stall3", 32'(stall3), 32'd1);
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_dout3", dout3, 32'h0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_err3", 32'(err3), 32'd0);
        chk("rst_erraddr0", erraddr0, 32'h0);
        chk("rst_erraddr3", erraddr3, 32'h0);

        #10 reset = 1'b1;
        #1;
        wait_init();

        access(1'b1, 1'b0, 32'h10, 32'h0);
        access(1'b0, 1'b1, 32'h8, 32'h9);
        access(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b0, 1'b0, 32'h0, 32'h0);
        access(1'b0, 1'b1, 32'h4, 32'h8);
        access(1'b1, 1'b0, 32'h4, 32'h0);
        access(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b0, 1'b1, 32'h0, 32'h55);
        access(1'b1, 1'b0, 32'h6, 32'h0);
        access(1'b0, 1'b1, 32'h400, 32'hdead_beef);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b1, 32'hC, 32'h77);
        access(1'b1, 1'b0, 32'hC, 32'h0);

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            a = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
            d = $urandom;
            if (r <= 3) begin
                access(1'b1, 1'b0, a, d);
            end else if (r <= 6) begin
                access(1'b0, 1'b1, a, d);
            end else if (r == 7) begin
                access(1'b0, 1'b0, a, d);
            end else if (r == 8) begin
                access(1'b1, 1'b1, a, d);
            end else begin
                if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(1, 3));
                else a = a | (32'($urandom_range(1, 255)) << 10);
                access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) , a, d);
            end
        end

        // Reset pulse landing in the second WAIT cycle of a READ_LAT=3 load.
        @(negedge clock);
        mem_read  = 1'b1;
        mem_write = 1'b0;
        addr      = 32'h8;
        #1;
        chk("midwait_first_stall3", 32'(stall3), 32'd1);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("midwait_second_stall3", 32'(stall3), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_stall0", 32'(stall0), 32'd1);
        chk("midrst_stall3", 32'(stall3), 32'd1);
        chk("midrst_dout0", dout0, 32'h0);
        chk("midrst_dout3", dout3, 32'h0);
        chk("midrst_err0", 32'(err0), 32'd0);
        chk("midrst_err3", 32'(err3), 32'd0);
        @(negedge clock);
        reset    = 1'b1;
        mem_read = 1'b0;
        model_reset();
        #1;
        wait_init();

        access(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b1, 1'b0, 32'h4, 32'h0);
        access(1'b1, 1'b0, 32'hC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
